// File: rtl/lcd_text_arbiter_if.sv
// Handshake bundle between text requesters, the arbiter and the LCD text sender.
// The arbiter takes the slave view; the requester/sender side takes the master view.
interface lcd_text_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int TEXT_BYTES = 34
);
    logic [NREQ-1:0]              req;
    logic [NREQ*8*TEXT_BYTES-1:0] text_in;
    logic [NREQ-1:0]              grant;
    logic [NREQ-1:0]              ack;
    logic                         send_text;
    logic [8*TEXT_BYTES-1:0]      text_out;
    logic                         sending_done;
    logic                         busy;
    logic                         timeout;

    modport master (
        output req,
        output text_in,
        output sending_done,
        input  grant,
        input  ack,
        input  send_text,
        input  text_out,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  text_in,
        input  sending_done,
        output grant,
        output ack,
        output send_text,
        output text_out,
        output busy,
        output timeout
    );
endinterface

// File: rtl/lcd_text_arbiter.sv
// Round-robin arbiter sharing one LCD text sender among NREQ requesters.
// Optional WAIT watchdog is enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_text_arbiter #(
    parameter int NREQ           = 4,
    parameter int TEXT_BYTES     = 34,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input logic               CLK,
    input logic               RST_N,
    lcd_text_arbiter_if.slave bus
);

    localparam int W  = 8 * TEXT_BYTES;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("lcd_text_arbiter: NREQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 67108864) begin : g_bad_tmo
        $error("lcd_text_arbiter: TIMEOUT_CYCLES must fit 26 bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT,
        S_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            send_q, send_d;
    logic [W-1:0]    text_q, text_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   own_q, own_d;
    logic            done_q, done_prev_q;
    logic            done_rise;

`ifdef LCD_ARB_TIMEOUT_EN
    logic [25:0]     wdog_q, wdog_d;
    logic            timeout_q, timeout_d;
    logic            wdog_hit;
`endif

    logic [IW-1:0]   win;
    logic            any_req;

    // Descending scan so the closest index after last_q overwrites the rest.
    always_comb begin
        win     = last_q;
        any_req = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[IW'((int'(last_q) + k) % NREQ)]) begin
                win     = IW'((int'(last_q) + k) % NREQ);
                any_req = 1'b1;
            end
        end
    end

    // Only a fresh rising edge of the sender's level counts as completion.
    assign done_rise = done_q & ~done_prev_q;

`ifdef LCD_ARB_TIMEOUT_EN
    assign wdog_hit = (wdog_q == 26'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        send_d  = 1'b0;
        text_d  = text_q;
        last_d  = last_q;
        own_d   = own_q;
`ifdef LCD_ARB_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    own_d   = win;
                    grant_d = NREQ'(1) << win;
                    text_d  = bus.text_in[int'(win)*W +: W];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                send_d  = 1'b1;
                state_d = S_START;
            end
            S_START: begin
`ifdef LCD_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    state_d = S_RELEASE;
                end
`ifdef LCD_ARB_TIMEOUT_EN
                else if (wdog_hit) begin
                    ack_d     = grant_q;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    wdog_d = wdog_q + 26'd1;
                end
`endif
            end
            S_RELEASE: begin
                last_d  = own_q;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            send_q      <= 1'b0;
            text_q      <= '0;
            last_q      <= IW'(NREQ - 1);
            own_q       <= '0;
            done_q      <= 1'b0;
            done_prev_q <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            send_q      <= send_d;
            text_q      <= text_d;
            last_q      <= last_d;
            own_q       <= own_d;
            done_q      <= bus.sending_done;
            done_prev_q <= done_q;
`ifdef LCD_ARB_TIMEOUT_EN
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.ack       = ack_q;
    assign bus.send_text = send_q;
    assign bus.text_out  = text_q;
    assign bus.busy      = (state_q != S_IDLE);
`ifdef LCD_ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Directed bench for lcd_text_arbiter: reset, handshake timing,
// round-robin order, stale done level, text latching, watchdog, abort.
module tb_lcd_text_arbiter;

    localparam int NREQ = 4;
    localparam int TB   = 4;
    localparam int W    = 8 * TB;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    lcd_text_arbiter_if #(.NREQ(NREQ), .TEXT_BYTES(TB)) bus ();

    lcd_text_arbiter #(
        .NREQ(NREQ),
        .TEXT_BYTES(TB),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] slice0(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic do_reset();
        RST_N = 1'b0;
        bus.req = '0;
        bus.sending_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_send(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.send_text;
        end
        chk({tag, "_send_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_ack(input string tag, input int max, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (n < max && !seen) begin
            tick();
            n++;
            seen = |bus.ack;
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic serve(input string tag, input int dly,
                         input logic [3:0] exp_g);
        int n;
        wait_send(tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(exp_g));
        repeat (dly) tick();
        bus.sending_done = 1'b1;
        wait_ack(tag, 10, n);
        chk({tag, "_ack"}, 32'(bus.ack), 32'(exp_g));
        bus.sending_done = 1'b0;
    endtask

    initial begin
        int n;
        logic [3:0] seen;

        bus.req = '0;
        bus.sending_done = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.text_in[i*W +: W] = slice0(i);

        // single requester handshake timing
        do_reset();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_send", 32'(bus.send_text), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_text", bus.text_out, 0);
        chk("rst_tmo", 32'(bus.timeout), 0);
        RST_N = 1'b1;
        bus.req = 4'b0001;
        tick();
        chk("t1_grant", 32'(bus.grant), 32'h1);
        chk("t1_text", bus.text_out, slice0(0));
        chk("t1_nosend", 32'(bus.send_text), 0);
        tick();
        chk("t1_send", 32'(bus.send_text), 1);
        repeat (10) tick();
        chk("t1_wait_busy", 32'(bus.busy), 1);
        bus.sending_done = 1'b1;
        wait_ack("t1", 10, n);
        chk("t1_ack_lat", 32'(n), 2);
        chk("t1_ack", 32'(bus.ack), 32'h1);
        chk("t1_rel_grant", 32'(bus.grant), 0);
        bus.req = '0;
        bus.sending_done = 1'b0;
        tick();
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_ack", 32'(bus.ack), 0);

        // round robin with all requests held
        do_reset();
        RST_N = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve($sformatf("rr%0d", i), 2, 4'(1 << (i % 4)));
            tick();
            chk($sformatf("rr%0d_gap", i), 32'(bus.busy), 0);
        end
        bus.req = '0;
        tick();

        // sending_done already high must not count
        do_reset();
        RST_N = 1'b1;
        bus.sending_done = 1'b1;
        bus.req = 4'b0001;
        wait_send("t3");
        seen = '0;
        repeat (6) begin
            tick();
            seen |= bus.ack;
        end
        chk("t3_no_ack", 32'(seen), 0);
        chk("t3_busy", 32'(bus.busy), 1);
        bus.sending_done = 1'b0;
        tick();
        tick();
        bus.sending_done = 1'b1;
        wait_ack("t3", 10, n);
        chk("t3_ack_lat", 32'(n), 2);
        chk("t3_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        bus.sending_done = 1'b0;
        tick();

        // text_out latched at grant
        bus.req = 4'b0010;
        wait_send("t4");
        chk("t4_grant", 32'(bus.grant), 32'h2);
        chk("t4_text", bus.text_out, slice0(1));
        bus.text_in[1*W +: W] = 32'hBEEF_0001;
        repeat (3) tick();
        chk("t4_text_hold", bus.text_out, slice0(1));
        bus.sending_done = 1'b1;
        wait_ack("t4", 10, n);
        bus.req = '0;
        bus.sending_done = 1'b0;
        tick();
        bus.req = 4'b0010;
        tick();
        chk("t4_regrant", 32'(bus.grant), 32'h2);
        chk("t4_newtext", bus.text_out, 32'hBEEF_0001);
        serve("t4b", 2, 4'b0010);
        bus.req = '0;
        tick();

        // stuck sender: watchdog or indefinite wait
        bus.req = 4'b0001;
        wait_send("t5");
`ifdef LCD_ARB_TIMEOUT_EN
        n = 0;
        while (n < 200 && !bus.timeout) begin
            tick();
            n++;
        end
        chk("t5_tmo_lat", 32'(n), 101);
        chk("t5_tmo_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        tick();
        chk("t5_tmo_pulse", 32'(bus.timeout), 0);
        chk("t5_idle", 32'(bus.busy), 0);
`else
        seen = '0;
        repeat (300) begin
            tick();
            seen[0] = seen[0] | bus.timeout;
            seen[1] = seen[1] | (|bus.ack);
        end
        chk("t5_busy", 32'(bus.busy), 1);
        chk("t5_no_tmo_ack", 32'(seen), 0);
        do_reset();
        RST_N = 1'b1;
`endif

        // reset during WAIT abandons the transfer
        bus.req = 4'b0100;
        wait_send("t6");
        chk("t6_grant", 32'(bus.grant), 32'h4);
        repeat (3) tick();
        RST_N = 1'b0;
        tick();
        chk("t6_grant0", 32'(bus.grant), 0);
        chk("t6_ack0", 32'(bus.ack), 0);
        chk("t6_send0", 32'(bus.send_text), 0);
        chk("t6_busy0", 32'(bus.busy), 0);
        chk("t6_text0", bus.text_out, 0);
        chk("t6_tmo0", 32'(bus.timeout), 0);
        RST_N = 1'b1;
        bus.req = 4'b0101;
        tick();
        chk("t6_rr_restart", 32'(bus.grant), 32'h1);
        chk("t6_ack_none", 32'(bus.ack), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_text_arbiter.md
LCD_TEXT_ARBITER -- requirements
Module: lcd_text_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of text requesters (2..8).
REQ-002 Parameter TEXT_BYTES, default 34, characters per message, 8 bits each, first character in the most significant byte.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000000, watchdog limit in CLK cycles (1 s at 50 MHz).
REQ-004 CLK  input  1  the single clock; all logic SHALL act on its rising edge.
REQ-005 RST_N  input  1  reset; synchronous and active-low.
REQ-006 req  input  NREQ  request level per requester, held until that requester's ack.
REQ-007 text_in  input  NREQ*8*TEXT_BYTES  concatenated messages, requester i at slice i.
REQ-008 grant  output  NREQ  one-hot owner of the LCD sender, all-zero when none.
REQ-009 ack  output  NREQ  one-cycle completion pulse to the owner.
REQ-010 send_text  output  1  one-cycle start pulse to the LCD text sender.
REQ-011 text_out  output  8*TEXT_BYTES  registered message presented to the LCD text sender.
REQ-012 sending_done  input  1  completion level from the LCD text sender.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout  output  1  one-cycle watchdog expiry pulse.

Function
REQ-015 States SHALL be IDLE, GRANT, START, WAIT and RELEASE, in that order of progression.
REQ-016 IDLE: if any req bit is set, the arbiter SHALL select the winner round-robin and go to GRANT; otherwise it stays in IDLE.
REQ-017 Round-robin: search starts at index (last_owner+1) mod NREQ and ascends with wrap; last_owner resets to NREQ-1, so requester 0 wins first after reset.
REQ-018 GRANT: grant SHALL be driven one-hot, text_out loaded from the winner's slice, and the state SHALL advance to START (grant high one cycle after req is sampled).
REQ-019 START: send_text SHALL be high for exactly this one cycle, then the state SHALL advance to WAIT.
REQ-020 WAIT: completion SHALL be a 0->1 transition of a registered copy of sending_done; a level already high on entry SHALL NOT count as completion.
REQ-021 RELEASE: the owner's ack bit SHALL pulse for one cycle, grant SHALL clear, last_owner SHALL update, and the state SHALL return to IDLE.
REQ-022 text_out SHALL hold constant from GRANT until the next GRANT; text_in changes after GRANT SHALL NOT affect it.
REQ-023 A req dropped before GRANT withdraws the request; a req dropped after GRANT SHALL NOT abort the transfer.
REQ-024 A req still high at ack SHALL be re-eligible, but SHALL rank last behind the other requesters.
REQ-025 Minimum turnaround from req to ack SHALL be 4 cycles plus the sender's duration; back-to-back grants SHALL include one IDLE cycle.
REQ-026 grant, ack and send_text SHALL never have more than one bit set; ack and send_text SHALL never be high together.

Reset
REQ-027 While RST_N is low at a clock edge: state = IDLE, grant = 0, ack = 0, send_text = 0, busy = 0, timeout = 0, text_out = 0, last_owner = NREQ-1, watchdog = 0.
REQ-028 Reset asserted mid-transfer SHALL abandon it with no ack and no timeout pulse.

Configuration
REQ-029 Macro LCD_ARB_TIMEOUT_EN defined: a 26-bit watchdog SHALL count in WAIT, cleared on WAIT entry; when it reaches TIMEOUT_CYCLES-1 without completion, timeout SHALL pulse one cycle and the FSM SHALL enter RELEASE.
REQ-030 In that expiry case, RELEASE SHALL still pulse ack.
REQ-031 Macro LCD_ARB_TIMEOUT_EN undefined: no watchdog logic SHALL exist, timeout SHALL be tied 0, and WAIT SHALL last until completion.

Verification
REQ-032 Reset, then req=4'b0001 with sending_done rising 10 cycles after send_text -> grant=0001 at cycle+1, send_text at +2, ack[0] pulse, busy low after.
REQ-033 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-034 sending_done held high before START -> no completion until it falls and rises again; ack only after that rise.
REQ-035 text_in slice 1 changed during WAIT of requester 1 -> text_out unchanged; the next grant of requester 1 loads the new text.
REQ-036 With LCD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, sending_done stuck low -> timeout pulse at the 100th WAIT cycle, then ack and IDLE; without the macro, busy stays high indefinitely.
REQ-037 RST_N low for one cycle during WAIT -> all outputs 0 next cycle, no ack, and requester 0 wins next.
